cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that merges EU result ports onto one
// registered common data bus entry, with backpressure and flush squash.
module cdb_arbiter #(
    parameter int unsigned EU_N        = 4,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ROB_IDX_LEN = 6,
    parameter int unsigned EXCEPT_LEN  = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [EU_N-1:0]               eu_valid_i,
    output logic [EU_N-1:0]               eu_ready_o,
    input  logic [EU_N*ROB_IDX_LEN-1:0]   eu_rob_idx_i,
    input  logic [EU_N*XLEN-1:0]          eu_value_i,
    input  logic [EU_N-1:0]               eu_except_raised_i,
    input  logic [EU_N*EXCEPT_LEN-1:0]    eu_except_code_i,
    output logic                          cdb_valid_o,
    input  logic                          cdb_ready_i,
    output logic [ROB_IDX_LEN-1:0]        cdb_rob_idx_o,
    output logic [XLEN-1:0]               cdb_value_o,
    output logic                          cdb_except_raised_o,
    output logic [EXCEPT_LEN-1:0]         cdb_except_code_o
);

    localparam int unsigned PTR_W = (EU_N > 1) ? $clog2(EU_N) : 1;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except_raised;
        logic [EXCEPT_LEN-1:0]  except_code;
    } cdb_entry_t;

    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_valid;
    cdb_entry_t       r_entry;

    logic             w_gnt_vld;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_load;
    logic             w_xfer;
    cdb_entry_t       w_sel;

    // Register can take a new entry when empty or being drained this cycle
    assign w_load = ~r_valid | cdb_ready_i;

    // Grant only when loadable, not flushing and out of reset
    assign w_xfer = w_gnt_vld & w_load & ~flush_i & rst_n_i;

    // Priority search starting at rr_ptr; lowest offset wins, so scan offsets high to low
    always_comb begin
        logic [PTR_W:0] v_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int k = int'(EU_N) - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (v_idx >= (PTR_W+1)'(EU_N)) begin
                v_idx = v_idx - (PTR_W+1)'(EU_N);
            end
            if (eu_valid_i[v_idx[PTR_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx[PTR_W-1:0];
            end
        end
    end

    // Pointer advances past the granted EU, wrapping for non-power-of-two EU_N
    assign w_ptr_next = (w_gnt_idx == PTR_W'(EU_N - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

    // Payload mux and one-hot ready for the granted EU
    always_comb begin
        w_sel      = '0;
        eu_ready_o = '0;
        for (int i = 0; i < int'(EU_N); i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_sel.rob_idx       = eu_rob_idx_i[i*ROB_IDX_LEN +: ROB_IDX_LEN];
                w_sel.value         = eu_value_i[i*XLEN +: XLEN];
                w_sel.except_raised = eu_except_raised_i[i];
                w_sel.except_code   = eu_except_code_i[i*EXCEPT_LEN +: EXCEPT_LEN];
                eu_ready_o[i]       = w_xfer;
            end
        end
    end

    // Output stage and round-robin pointer; flush squashes the entry and rewinds priority
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr_ptr <= '0;
            r_valid  <= 1'b0;
            r_entry  <= '0;
        end else if (flush_i) begin
            r_rr_ptr <= '0;
            r_valid  <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr <= w_ptr_next;
            r_valid  <= 1'b1;
            r_entry  <= w_sel;
        end else if (cdb_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign cdb_valid_o         = r_valid;
    assign cdb_rob_idx_o       = r_entry.rob_idx;
    assign cdb_value_o         = r_entry.value;
    assign cdb_except_raised_o = r_entry.except_raised;
    assign cdb_except_code_o   = r_entry.except_code;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (EU_N=4).
module tb_cdb_arbiter;

    localparam int unsigned EU_N = 4;
    localparam int unsigned XLEN = 64;
    localparam int unsigned RW   = 6;
    localparam int unsigned EW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [EU_N-1:0]      eu_valid;
    logic [EU_N-1:0]      eu_ready;
    logic [EU_N*RW-1:0]   eu_rob_idx;
    logic [EU_N*XLEN-1:0] eu_value;
    logic [EU_N-1:0]      eu_exc;
    logic [EU_N*EW-1:0]   eu_code;
    logic                 cdb_valid;
    logic                 cdb_ready;
    logic [RW-1:0]        cdb_rob_idx;
    logic [XLEN-1:0]      cdb_value;
    logic                 cdb_exc;
    logic [EW-1:0]        cdb_code;

    int total = 0;
    int bad   = 0;

    // Fixed per-EU payloads; EU2 carries rob_idx 5 / value 0xDEAD
    logic [RW-1:0]   src_rob  [EU_N] = '{6'd1, 6'd3, 6'd5, 6'd7};
    logic [XLEN-1:0] src_val  [EU_N] = '{64'hA0, 64'hB1, 64'hDEAD, 64'hC3C3_0000_1234_5678};
    logic            src_exc  [EU_N] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [EW-1:0]   src_code [EU_N] = '{5'd1, 5'd2, 5'd3, 5'd4};

    cdb_arbiter #(.EU_N(EU_N), .XLEN(XLEN), .ROB_IDX_LEN(RW), .EXCEPT_LEN(EW)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .flush_i            (flush),
        .eu_valid_i         (eu_valid),
        .eu_ready_o         (eu_ready),
        .eu_rob_idx_i       (eu_rob_idx),
        .eu_value_i         (eu_value),
        .eu_except_raised_i (eu_exc),
        .eu_except_code_i   (eu_code),
        .cdb_valid_o        (cdb_valid),
        .cdb_ready_i        (cdb_ready),
        .cdb_rob_idx_o      (cdb_rob_idx),
        .cdb_value_o        (cdb_value),
        .cdb_except_raised_o(cdb_exc),
        .cdb_except_code_o  (cdb_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       fl;
        logic [3:0] exp_ready;
        logic       exp_cv;
        int         exp_src;   // EU whose payload is on the CDB; -1 when invalid
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_payload(input string tag, input int src);
        check({tag, "_rob"},  64'(cdb_rob_idx), 64'(src_rob[src]));
        check({tag, "_val"},  cdb_value,        src_val[src]);
        check({tag, "_exc"},  64'(cdb_exc),     64'(src_exc[src]));
        check({tag, "_code"}, 64'(cdb_code),    64'(src_code[src]));
    endtask

    initial begin
        for (int i = 0; i < int'(EU_N); i++) begin
            eu_rob_idx[i*RW +: RW]   = src_rob[i];
            eu_value[i*XLEN +: XLEN] = src_val[i];
            eu_exc[i]                = src_exc[i];
            eu_code[i*EW +: EW]      = src_code[i];
        end

        //          valid    rdy   fl    ready    cv    src
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, -1}; // lone EU2 granted
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1,  2}; // EU2 visible after 1 cycle
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, -1}; // flush rewinds pointer
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, -1};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1,  0};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1,  1};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1,  2};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1,  3};
        vecs[8]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1,  0}; // EU1 onto CDB
        vecs[9]  = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1,  1}; // backpressure x3
        vecs[10] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1,  1};
        vecs[11] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1,  1};
        vecs[12] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1,  1}; // release: EU3 from ptr 2
        vecs[13] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1,  3}; // EU2 -> ptr 3
        vecs[14] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1,  2}; // EU3 first
        vecs[15] = '{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1,  3}; // then wrap to EU0
        vecs[16] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b1,  0}; // flush with entry valid
        vecs[17] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, -1}; // EU0 granted after flush
        vecs[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1,  0};
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1,  0};

        // Reset state with all EUs requesting
        rst_n     = 1'b0;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        eu_valid  = 4'b1111;
        #12;
        check("rst_ready", 64'(eu_ready),  64'd0);
        check("rst_cv",    64'(cdb_valid), 64'd0);
        check("rst_rob",   64'(cdb_rob_idx), 64'd0);
        check("rst_val",   cdb_value,      64'd0);
        eu_valid = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 20; v++) begin
            @(posedge clk); #1;
            eu_valid  = vecs[v].valid;
            cdb_ready = vecs[v].rdy;
            flush     = vecs[v].fl;
            #4;
            check($sformatf("v%0d_ready", v), 64'(eu_ready),  64'(vecs[v].exp_ready));
            check($sformatf("v%0d_cv", v),    64'(cdb_valid), 64'(vecs[v].exp_cv));
            if (vecs[v].exp_src >= 0) check_payload($sformatf("v%0d", v), vecs[v].exp_src);
        end

        // Asynchronous reset mid-stream while the CDB holds EU0's entry
        @(posedge clk); #1;
        eu_valid  = 4'b1111;
        cdb_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check("pre_arst_cv", 64'(cdb_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_cv",    64'(cdb_valid),   64'd0);
        check("arst_ready", 64'(eu_ready),    64'd0);
        check("arst_rob",   64'(cdb_rob_idx), 64'd0);
        check("arst_val",   cdb_value,        64'd0);
        check("arst_exc",   64'(cdb_exc),     64'd0);
        check("arst_code",  64'(cdb_code),    64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        cdb_ready = 1'b1;
        #3;
        check("post_rst_ready", 64'(eu_ready), 64'b0001);
        @(posedge clk); #1;
        eu_valid = 4'b0000;
        #3;
        check("post_rst_cv", 64'(cdb_valid), 64'd1);
        check_payload("post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
